// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   // Winner index for a fresh arbitration; on a tie the master that did not go last wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic rr_last);
      if (req == 2'b11) return ~rr_last;
      return req[1] & ~req[0];
   endfunction

endpackage

// File: rtl/wshb_arb_fsm.sv
// Ownership FSM: tracks the current bus owner, round-robin history and the debug grant vector.
module wshb_arb_fsm
   import wshb_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   output arb_state_e state_o,
   output logic [1:0] gnt_o
);

   arb_state_e state_q, state_d;
   logic       rr_last_q, rr_last_d;
   logic [1:0] gnt_q, gnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
         gnt_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         gnt_q     <= gnt_d;
      end
   end

   // An owner keeps the bus until it drops cyc; hand-over to a waiting master skips IDLE.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      case (state_q)
         IDLE: if (|req_i) state_d = rr_pick(req_i, rr_last_q) ? GNT1 : GNT0;
         GNT0: if (!req_i[0]) begin
            rr_last_d = 1'b0;
            state_d   = req_i[1] ? GNT1 : IDLE;
         end
         GNT1: if (!req_i[1]) begin
            rr_last_d = 1'b1;
            state_d   = req_i[0] ? GNT0 : IDLE;
         end
         default: state_d = IDLE;
      endcase
      gnt_d = {state_d == GNT1, state_d == GNT0};
   end

   assign state_o = state_q;
   assign gnt_o   = gnt_q;

endmodule

// File: rtl/wshb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter: slave-side request mux and owner-gated return path.
module wshb_arbiter_2m
   import wshb_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_cyc,
   input  logic                m0_stb,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_adr,
   input  logic [DATA_W-1:0]   m0_dat_ms,
   input  logic [DATA_W/8-1:0] m0_sel,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_dat_sm,
   input  logic                m1_cyc,
   input  logic                m1_stb,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_adr,
   input  logic [DATA_W-1:0]   m1_dat_ms,
   input  logic [DATA_W/8-1:0] m1_sel,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_dat_sm,
   output logic                s_cyc,
   output logic                s_stb,
   output logic                s_we,
   output logic [ADDR_W-1:0]   s_adr,
   output logic [DATA_W-1:0]   s_dat_ms,
   output logic [DATA_W/8-1:0] s_sel,
   input  logic                s_ack,
   input  logic [DATA_W-1:0]   s_dat_sm,
   output logic [1:0]          gnt
);

   arb_state_e state;

   wshb_arb_fsm u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   ({m1_cyc, m0_cyc}),
      .state_o (state),
      .gnt_o   (gnt)
   );

   // Mux is driven purely from registered state, so s_ack never reaches s_cyc/s_stb.
   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_ms = '0;
      s_sel    = '0;
      case (state)
         GNT0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
         end
         GNT1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
         end
         default: ;
      endcase
   end

   assign m0_ack    = s_ack & (state == GNT0);
   assign m1_ack    = s_ack & (state == GNT1);
   assign m0_dat_sm = s_dat_sm;
   assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// Directed bench for wshb_arbiter_2m with a 2-cycle-latency slave returning adr+0x100.
module tb_wshb_arbiter_2m;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_adr, m0_dat_ms, m1_adr, m1_dat_ms;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_dat_sm, m1_dat_sm;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_dat_ms;
   logic [3:0]  s_sel;
   logic        s_ack;
   logic [31:0] s_dat_sm;
   logic [1:0]  gnt;

   int          errs = 0;
   int          checks = 0;
   int          ack_cnt;
   logic        p1_v = 1'b0, p2_v = 1'b0;
   logic [31:0] p1_a = '0, p2_a = '0;

   always #5 clk = ~clk;

   wshb_arbiter_2m #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
      .gnt(gnt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   // One clock; the slave model samples the request before the edge and acks two cycles later.
   task automatic tick();
      logic        req;
      logic [31:0] a;
      req = s_cyc & s_stb;
      a   = s_adr;
      @(posedge clk);
      #1;
      p2_v = p1_v; p2_a = p1_a;
      p1_v = req;  p1_a = a;
      s_ack    = p2_v;
      s_dat_sm = p2_v ? p2_a + 32'h100 : 32'hDEAD_BEEF;
   endtask

   task automatic chk_acks(input int own, input logic [31:0] base);
      if (own == 0) begin
         chk("m1_ack_idle", 32'(m1_ack), 0);
         chk("m0_ack", 32'(m0_ack), 32'(s_ack));
      end else begin
         chk("m0_ack_idle", 32'(m0_ack), 0);
         chk("m1_ack", 32'(m1_ack), 32'(s_ack));
      end
      if (s_ack) begin
         chk("rd_data", (own == 0) ? m0_dat_sm : m1_dat_sm, base + 32'h100 + 32'(ack_cnt) * 4);
         ack_cnt++;
      end
   endtask

   task automatic set_m(input int own, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
      if (own == 0) begin
         m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_ms = dat; m0_sel = 4'hF;
      end else begin
         m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_ms = dat; m1_sel = 4'h3;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
      s_ack = 0; s_dat_sm = '0;

      // reset state
      #2;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_s_cyc", 32'(s_cyc), 0);
      chk("rst_m0_ack", 32'(m0_ack), 0);
      @(negedge clk) rst_n = 1'b1;
      tick(); #1 chk("idle_gnt_a", 32'(gnt), 0);
      tick(); #1 chk("idle_gnt_b", 32'(gnt), 0);

      // single master: 4 pipelined reads
      ack_cnt = 0;
      set_m(0, 1, 0, 0, 0, 0);
      tick(); #1;
      chk("m0_gnt", 32'(gnt), 32'h1);
      chk("m0_s_cyc", 32'(s_cyc), 1);
      for (int i = 0; i < 4; i++) begin
         set_m(0, 1, 1, 0, 32'(i) * 4, 0);
         #1;
         chk("rd_s_stb", 32'(s_stb), 1);
         chk("rd_s_adr", s_adr, 32'(i) * 4);
         chk_acks(0, 0);
         tick();
      end
      set_m(0, 1, 0, 0, 0, 0);
      for (int n = 0; n < 8 && ack_cnt < 4; n++) begin
         #1 chk_acks(0, 0);
         tick();
      end
      chk("rd_ack_cnt", 32'(ack_cnt), 4);
      m0_cyc = 0;
      #1 chk("rd_gnt_hold", 32'(gnt), 32'h1);
      tick(); #1;
      chk("rd_gnt_rel", 32'(gnt), 0);
      chk("rd_s_cyc_rel", 32'(s_cyc), 0);

      // simultaneous first request after reset
      rst_n = 1'b0;
      #1 chk("rst2_gnt", 32'(gnt), 0);
      #2 rst_n = 1'b1;
      m0_cyc = 1; m1_cyc = 1;
      tick(); #1;
      chk("tie_gnt0", 32'(gnt), 32'h1);
      chk("tie_s_cyc", 32'(s_cyc), 1);
      m0_cyc = 0;
      #1 chk("tie_s_cyc_drop", 32'(s_cyc), 0);
      tick(); #1;
      chk("handover_gnt1", 32'(gnt), 32'h2);
      chk("handover_s_cyc", 32'(s_cyc), 1);
      m1_cyc = 0;
      tick(); #1 chk("tie_end_gnt", 32'(gnt), 0);

      // fairness: both keep requesting, 1-word writes
      m0_cyc = 1; m1_cyc = 1;
      tick();
      for (int t = 0; t < 8; t++) begin
         int own;
         own = t % 2;
         #1 chk("fair_gnt", 32'(gnt), (own == 0) ? 32'h1 : 32'h2);
         set_m(own, 1, 1, 1, 32'h2000 + 32'(t) * 4, 32'hA0 + 32'(t));
         #1;
         chk("fair_s_we", 32'(s_we), 1);
         chk("fair_s_adr", s_adr, 32'h2000 + 32'(t) * 4);
         chk("fair_s_dat", s_dat_ms, 32'hA0 + 32'(t));
         chk("fair_s_sel", 32'(s_sel), (own == 0) ? 32'hF : 32'h3);
         tick();
         set_m(own, 1, 0, 0, 0, 0);
         tick(); #1;
         chk("fair_own_ack", 32'((own == 0) ? m0_ack : m1_ack), 1);
         chk("fair_oth_ack", 32'((own == 0) ? m1_ack : m0_ack), 0);
         tick();
         set_m(own, 0, 0, 0, 0, 0);
         tick();
         set_m(own, 1, 0, 0, 0, 0);
      end
      #1 chk("fair_gnt_9th", 32'(gnt), 32'h1);
      m0_cyc = 0; m1_cyc = 0;
      tick(); #1 chk("fair_end_gnt", 32'(gnt), 0);

      // no pre-emption during a 16-word burst
      ack_cnt = 0;
      set_m(0, 1, 0, 0, 0, 0);
      tick();
      set_m(1, 1, 1, 0, 32'hBAD0, 0);
      for (int i = 0; i < 16; i++) begin
         set_m(0, 1, 1, 0, 32'h1000 + 32'(i) * 4, 0);
         #1;
         chk("burst_gnt", 32'(gnt), 32'h1);
         chk("burst_s_adr", s_adr, 32'h1000 + 32'(i) * 4);
         chk_acks(0, 32'h1000);
         tick();
      end
      set_m(0, 1, 0, 0, 0, 0);
      for (int n = 0; n < 8 && ack_cnt < 16; n++) begin
         #1 chk_acks(0, 32'h1000);
         tick();
      end
      chk("burst_ack_cnt", 32'(ack_cnt), 16);
      m0_cyc = 0;
      #1 chk("burst_gnt_last", 32'(gnt), 32'h1);
      tick(); #1;
      chk("burst_handover", 32'(gnt), 32'h2);
      chk("burst_m1_adr", s_adr, 32'hBAD0);
      set_m(1, 0, 0, 0, 0, 0);
      tick(); #1 chk("burst_end_gnt", 32'(gnt), 0);

      // stray acks
      s_ack = 1; s_dat_sm = 32'h5555_5555;
      #1;
      chk("stray_idle_m0", 32'(m0_ack), 0);
      chk("stray_idle_m1", 32'(m1_ack), 0);
      tick(); #1 chk("stray_idle_gnt", 32'(gnt), 0);
      m1_cyc = 1;
      tick(); #1 chk("stray_m1_gnt", 32'(gnt), 32'h2);
      m1_cyc = 0;
      tick();
      s_ack = 1;
      #1;
      chk("stray_late_m0", 32'(m0_ack), 0);
      chk("stray_late_m1", 32'(m1_ack), 0);
      chk("stray_late_gnt", 32'(gnt), 0);
      tick(); #1;
      chk("stray_after_gnt", 32'(gnt), 0);
      chk("stray_after_cyc", 32'(s_cyc), 0);

      // asynchronous reset in the middle of a transfer
      set_m(0, 1, 1, 0, 32'h40, 0);
      tick(); #1 chk("mid_s_cyc", 32'(s_cyc), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_s_cyc", 32'(s_cyc), 0);
      chk("mid_rst_s_stb", 32'(s_stb), 0);
      chk("mid_rst_gnt", 32'(gnt), 0);
      set_m(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      tick(); #1 chk("post_rst_gnt", 32'(gnt), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
